// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences one instruction
// over 3-5 cycles and drives every datapath mux select and write enable.
module multicycle_control #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_en,
   output logic               ir_write,
   output logic               mem_write,
   output logic               iord,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_op,
   output logic [1:0]         pc_src,
   output logic               ext_op,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      RTYPE_EX = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      IMM_EX   = 4'd9,
      IMMWB    = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   state_t     state_reg;
   state_t     state_next;
   logic [2:0] imm_alu_op;
   logic       imm_ext_op;

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= FETCH;
      else
         state_reg <= state_next;
   end

   // Logical immediates are zero-extended; addi keeps sign extension.
   always_comb begin
      imm_alu_op = 3'b000;
      imm_ext_op = 1'b1;
      if (opcode == OP_ANDI) begin
         imm_alu_op = 3'b011;
         imm_ext_op = 1'b0;
      end else if (opcode == OP_ORI) begin
         imm_alu_op = 3'b100;
         imm_ext_op = 1'b0;
      end
   end

   always_comb begin
      state_next = FETCH;
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      pc_src     = 2'b00;
      ext_op     = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      // Outputs are held low during reset so no write leaks out before the
      // state register has actually returned to FETCH.
      if (!reset) begin
         case (state_reg)
            FETCH: begin
               alu_src_b  = 2'b01;
               ir_write   = mem_ready;
               pc_en      = mem_ready;
               state_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               ext_op    = 1'b1;
               case (opcode)
                  OP_LW, OP_SW:           state_next = MEMADR;
                  OP_RTYPE:               state_next = RTYPE_EX;
                  OP_BEQ, OP_BNE:         state_next = BRANCH;
                  OP_ADDI, OP_ANDI, OP_ORI: state_next = IMM_EX;
                  OP_J:                   state_next = JUMP;
                  default: begin
                     illegal_op = 1'b1;
                     instr_done = 1'b1;
                     state_next = FETCH;
                  end
               endcase
            end
            MEMADR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               ext_op     = 1'b1;
               state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
               iord       = 1'b1;
               state_next = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            MEMWR: begin
               iord       = 1'b1;
               mem_write  = 1'b1;
               instr_done = mem_ready;
               state_next = mem_ready ? FETCH : MEMWR;
            end
            RTYPE_EX: begin
               alu_src_a  = 1'b1;
               alu_op     = 3'b010;
               state_next = ALUWB;
            end
            ALUWB: begin
               reg_dst    = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            BRANCH: begin
               alu_src_a  = 1'b1;
               alu_op     = 3'b001;
               pc_src     = 2'b01;
               instr_done = 1'b1;
               pc_en      = (opcode == OP_BNE) ? ~zero : zero;
            end
            IMM_EX: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               alu_op     = imm_alu_op;
               ext_op     = imm_ext_op;
               state_next = IMMWB;
            end
            IMMWB: begin
               alu_op     = imm_alu_op;
               ext_op     = imm_ext_op;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            JUMP: begin
               pc_src     = 2'b10;
               pc_en      = 1'b1;
               instr_done = 1'b1;
            end
            default: state_next = FETCH;
         endcase
      end
   end

   assign state = reset ? '0 : STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed
// per-cycle output vectors, a negedge monitor pops and compares them.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg;
   logic       alu_src_a, ext_op, instr_done, illegal_op;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_op;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [21:0] vec;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   multicycle_control #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .iord(iord),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .ext_op(ext_op), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // Vector layout: state, pc_en, ir_write, mem_write, iord, reg_write, reg_dst,
   // mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, ext_op, instr_done, illegal_op
   function automatic logic [21:0] mk(input logic [3:0] st, input logic pe, input logic irw,
                                      input logic mw, input logic io, input logic rw,
                                      input logic rd, input logic m2r, input logic asa,
                                      input logic [1:0] asb, input logic [2:0] aop,
                                      input logic [1:0] ps, input logic ext,
                                      input logic dn, input logic ill);
      return {st, pe, irw, mw, io, rw, rd, m2r, asa, asb, aop, ps, ext, dn, ill};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t        e;
         logic [21:0] got;
         e   = exp_q.pop_front();
         got = {state, pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_src, ext_op, instr_done, illegal_op};
         total++;
         if (got !== e.vec) begin
            bad++;
            $display("FAIL %s: got=%06h expected=%06h", e.name, got, e.vec);
         end
      end
   end

   task automatic cyc(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                      input logic [21:0] v, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rst;
      opcode    = op;
      zero      = z;
      mem_ready = mr;
      e.vec     = v;
      e.name    = nm;
      exp_q.push_back(e);
   endtask

   logic [21:0] idle_v, fetch_v, fetch_stall_v, decode_v;

   initial begin
      reset = 1'b1; opcode = 6'h23; zero = 1'b0; mem_ready = 1'b1;
      idle_v        = '0;
      fetch_v       = mk(4'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0, 0);
      fetch_stall_v = mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0, 0);
      decode_v      = mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 1, 0, 0);

      $display("txn reset hold 3 cycles");
      repeat (3) cyc(1, 6'h23, 0, 1, idle_v, "reset_hold");

      $display("txn lw");
      cyc(0, 6'h23, 0, 1, fetch_v, "lw_fetch");
      cyc(0, 6'h23, 0, 1, decode_v, "lw_decode");
      cyc(0, 6'h23, 0, 1, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 1, 0, 0), "lw_memadr");
      cyc(0, 6'h23, 0, 1, mk(4'd3, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0), "lw_memrd");
      cyc(0, 6'h23, 0, 1, mk(4'd4, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0), "lw_memwb");

      $display("txn sw with 2 wait cycles");
      cyc(0, 6'h2B, 0, 0, fetch_stall_v, "sw_fetch_stall");
      cyc(0, 6'h2B, 0, 1, fetch_v, "sw_fetch");
      cyc(0, 6'h2B, 0, 1, decode_v, "sw_decode");
      cyc(0, 6'h2B, 0, 1, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 1, 0, 0), "sw_memadr");
      cyc(0, 6'h2B, 0, 0, mk(4'd5, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0), "sw_memwr_wait1");
      cyc(0, 6'h2B, 0, 0, mk(4'd5, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0), "sw_memwr_wait2");
      cyc(0, 6'h2B, 0, 1, mk(4'd5, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0), "sw_memwr_done");

      $display("txn rtype");
      cyc(0, 6'h00, 0, 1, fetch_v, "rt_fetch");
      cyc(0, 6'h00, 0, 1, decode_v, "rt_decode");
      cyc(0, 6'h00, 0, 1, mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0, 0), "rt_ex");
      cyc(0, 6'h00, 0, 1, mk(4'd7, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0), "rt_wb");

      $display("txn beq zero=1");
      cyc(0, 6'h04, 1, 1, fetch_v, "beq_fetch");
      cyc(0, 6'h04, 1, 1, decode_v, "beq_decode");
      cyc(0, 6'h04, 1, 1, mk(4'd8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0, 1, 0), "beq_branch");

      $display("txn bne zero=1");
      cyc(0, 6'h05, 1, 1, fetch_v, "bne_fetch");
      cyc(0, 6'h05, 1, 1, decode_v, "bne_decode");
      cyc(0, 6'h05, 1, 1, mk(4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0, 1, 0), "bne_branch");

      $display("txn andi");
      cyc(0, 6'h0C, 0, 1, fetch_v, "andi_fetch");
      cyc(0, 6'h0C, 0, 1, decode_v, "andi_decode");
      cyc(0, 6'h0C, 0, 1, mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b011, 2'b00, 0, 0, 0), "andi_ex");
      cyc(0, 6'h0C, 0, 1, mk(4'd10, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b011, 2'b00, 0, 1, 0), "andi_wb");

      $display("txn addi");
      cyc(0, 6'h08, 0, 1, fetch_v, "addi_fetch");
      cyc(0, 6'h08, 0, 1, decode_v, "addi_decode");
      cyc(0, 6'h08, 0, 1, mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 1, 0, 0), "addi_ex");
      cyc(0, 6'h08, 0, 1, mk(4'd10, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 1, 0), "addi_wb");

      $display("txn ori");
      cyc(0, 6'h0D, 0, 1, fetch_v, "ori_fetch");
      cyc(0, 6'h0D, 0, 1, decode_v, "ori_decode");
      cyc(0, 6'h0D, 0, 1, mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 2'b00, 0, 0, 0), "ori_ex");
      cyc(0, 6'h0D, 0, 1, mk(4'd10, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b100, 2'b00, 0, 1, 0), "ori_wb");

      $display("txn j");
      cyc(0, 6'h02, 0, 1, fetch_v, "j_fetch");
      cyc(0, 6'h02, 0, 1, decode_v, "j_decode");
      cyc(0, 6'h02, 0, 1, mk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 1, 0), "j_jump");

      $display("txn illegal 0x3F");
      cyc(0, 6'h3F, 0, 1, fetch_v, "ill_fetch");
      cyc(0, 6'h3F, 0, 1, mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 1, 1, 1), "ill_decode");
      cyc(0, 6'h3F, 0, 0, fetch_stall_v, "ill_back_to_fetch");

      $display("txn lw aborted by reset in MEMRD");
      cyc(0, 6'h23, 0, 1, fetch_v, "abort_fetch");
      cyc(0, 6'h23, 0, 1, decode_v, "abort_decode");
      cyc(0, 6'h23, 0, 1, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 1, 0, 0), "abort_memadr");
      cyc(0, 6'h23, 0, 0, mk(4'd3, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0), "abort_memrd");
      cyc(1, 6'h23, 0, 1, idle_v, "abort_reset");
      cyc(0, 6'h23, 0, 0, fetch_stall_v, "abort_after_reset");
      cyc(0, 6'h23, 0, 0, fetch_stall_v, "abort_no_write");

      begin
         int budget;
         budget = 20;
         while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
